// File: rtl/tmp_conv_sched.sv
// rtl/tmp_conv_sched.sv - temperature conversion scheduler with sample averaging
// Sequences sensor reset/measure cycles, averages 2^avg_log2 samples and hands results to the host.
module tmp_conv_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cont_en,
  input  logic [15:0] period,
  input  logic [1:0]  avg_log2,
  input  logic [11:0] timeout,
  output logic        sns_rst,
  input  logic        sns_done,
  output logic [11:0] result,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        busy,
  output logic        err_timeout
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SRST = 3'd1;
  localparam logic [2:0] S_MEAS = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [1:0]  srst_cnt_q, srst_cnt_d;
  logic [11:0] meas_cnt_q, meas_cnt_d;
  logic [14:0] acc_q, acc_d;
  logic [3:0]  n_cnt_q, n_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        done_q, done_d;
  logic [15:0] period_q, period_d;
  logic [1:0]  avg_q, avg_d;
  logic [11:0] timeout_q, timeout_d;
  logic        err_q, err_d;
  logic [11:0] result_q, result_d;

  logic        done_rise;
  logic [14:0] acc_sum;
  logic [3:0]  n_next;
  logic [3:0]  n_target;

  always_comb begin
    state_d    = state_q;
    srst_cnt_d = srst_cnt_q;
    meas_cnt_d = meas_cnt_q;
    acc_d      = acc_q;
    n_cnt_d    = n_cnt_q;
    wait_cnt_d = wait_cnt_q;
    period_d   = period_q;
    avg_d      = avg_q;
    timeout_d  = timeout_q;
    err_d      = err_q;
    result_d   = result_q;
    done_d     = sns_done;

    // done_q tracks the level every cycle, so a level already high on MEASURE entry never looks like a rise
    done_rise = sns_done & ~done_q;
    acc_sum   = acc_q + {3'b000, meas_cnt_q};
    n_next    = n_cnt_q + 4'd1;
    n_target  = 4'd1 << avg_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          period_d   = period;
          avg_d      = avg_log2;
          timeout_d  = timeout;
          err_d      = 1'b0;
          srst_cnt_d = 2'd0;
          meas_cnt_d = 12'd0;
          state_d    = S_SRST;
        end
      end
      S_SRST: begin
        if (srst_cnt_q == 2'd3) begin
          state_d = S_MEAS;
        end else begin
          srst_cnt_d = srst_cnt_q + 2'd1;
        end
      end
      S_MEAS: begin
        if (done_rise) begin
          acc_d   = acc_sum;
          n_cnt_d = n_next;
          if (n_next == n_target) begin
            result_d = 12'(acc_sum >> avg_q);
            state_d  = S_OUT;
          end else begin
            srst_cnt_d = 2'd0;
            meas_cnt_d = 12'd0;
            state_d    = S_SRST;
          end
        end else if (meas_cnt_q == timeout_q) begin
          err_d   = 1'b1;
          acc_d   = 15'd0;
          n_cnt_d = 4'd0;
          state_d = S_IDLE;
        end else begin
          meas_cnt_d = meas_cnt_q + 12'd1;
        end
      end
      S_OUT: begin
        if (result_ready) begin
          acc_d   = 15'd0;
          n_cnt_d = 4'd0;
          if (cont_en) begin
            wait_cnt_d = period_q;
            state_d    = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT: begin
        if (!cont_en) begin
          state_d = S_IDLE;
        end else if (wait_cnt_q == 16'd0) begin
          srst_cnt_d = 2'd0;
          meas_cnt_d = 12'd0;
          state_d    = S_SRST;
        end else begin
          wait_cnt_d = wait_cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      srst_cnt_q <= 2'd0;
      meas_cnt_q <= 12'd0;
      acc_q      <= 15'd0;
      n_cnt_q    <= 4'd0;
      wait_cnt_q <= 16'd0;
      done_q     <= 1'b0;
      period_q   <= 16'd0;
      avg_q      <= 2'd0;
      timeout_q  <= 12'd0;
      err_q      <= 1'b0;
      result_q   <= 12'd0;
    end else begin
      state_q    <= state_d;
      srst_cnt_q <= srst_cnt_d;
      meas_cnt_q <= meas_cnt_d;
      acc_q      <= acc_d;
      n_cnt_q    <= n_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      done_q     <= done_d;
      period_q   <= period_d;
      avg_q      <= avg_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
      result_q   <= result_d;
    end
  end

  assign sns_rst      = (state_q != S_MEAS);
  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_OUT);
  assign result       = result_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_tmp_conv_sched.sv
// tb/tb_tmp_conv_sched.sv - self-checking bench for tmp_conv_sched
// Reference: result = integer mean of the sample list, sample = cycles from MEASURE entry to sns_done rise.
module tb_tmp_conv_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cont_en = 1'b0;
  logic [15:0] period = 16'd0;
  logic [1:0]  avg_log2 = 2'd0;
  logic [11:0] timeout = 12'd0;
  logic        sns_rst;
  logic        sns_done = 1'b0;
  logic [11:0] result;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic        busy;
  logic        err_timeout;

  int tests_run = 0;
  int tests_failed = 0;
  int samp[$];
  int exp_result = 0;

  tmp_conv_sched dut (
    .clk(clk), .reset(reset), .start(start), .cont_en(cont_en), .period(period),
    .avg_log2(avg_log2), .timeout(timeout), .sns_rst(sns_rst), .sns_done(sns_done),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sns_rst"}, sns_rst, 1);
    check({tag, "_result"}, result, 0);
    check({tag, "_valid"}, result_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err_timeout, 0);
  endtask

  // Start in IDLE, then scramble the config pins: the latched values must be used.
  task automatic start_conv(input int avg, input int tmo, input int per);
    avg_log2 = avg[1:0];
    timeout  = tmo[11:0];
    period   = per[15:0];
    start    = 1'b1;
    tick();
    start    = 1'b0;
    avg_log2 = 2'($urandom);
    timeout  = 12'($urandom_range(0, 3));
    period   = 16'($urandom_range(100, 200));
  endtask

  task automatic measure_one(input int s, input int exp_rst, input string tag);
    int n = 0;
    while (sns_rst === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check({tag, "_rst_cycles"}, n, exp_rst);
    repeat (s) tick();
    sns_done = 1'b1;
    tick();
    sns_done = 1'b0;
  endtask

  task automatic run_set(input int avg, input int first_rst, input string tag);
    int sum = 0;
    for (int i = 0; i < (1 << avg); i++) begin
      measure_one(samp[i], (i == 0) ? first_rst : 4, tag);
      sum += samp[i];
    end
    exp_result = sum / (1 << avg);
    check({tag, "_valid"}, result_valid, 1);
    check({tag, "_result"}, result, exp_result);
  endtask

  task automatic accept(input bit cont, input string tag);
    int hold = $urandom_range(0, 3);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, result_valid, 1);
      check({tag, "_hold_result"}, result, exp_result);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check({tag, "_valid_drop"}, result_valid, 0);
    check({tag, "_busy_after"}, busy, {31'd0, cont});
  endtask

  task automatic expect_timeout(input int tmo, input string tag);
    int n = 0;
    bit seen_valid = 1'b0;
    while (busy === 1'b1 && n < 5000) begin
      if (result_valid === 1'b1) seen_valid = 1'b1;
      n++;
      tick();
    end
    check({tag, "_busy_cycles"}, n, tmo + 5);
    check({tag, "_err"}, err_timeout, 1);
    check({tag, "_no_valid"}, {31'd0, seen_valid}, 0);
  endtask

  initial begin
    int avg;
    int per;

    tick();
    tick();
    check_reset_vals("reset");
    reset = 1'b0;
    tick();

    // Single sample
    samp = '{100};
    start_conv(0, 4095, 0);
    check("single_busy", busy, 1);
    run_set(0, 4, "single");
    accept(1'b0, "single");
    check("single_err", err_timeout, 0);

    // Averaging of four samples
    samp = '{100, 101, 102, 105};
    start_conv(2, 4095, 0);
    run_set(2, 4, "avg4");
    accept(1'b0, "avg4");

    // Randomized averaging against the mean model
    for (int k = 0; k < 6; k++) begin
      avg = $urandom_range(0, 3);
      samp.delete();
      for (int i = 0; i < 8; i++) samp.push_back($urandom_range(0, 200));
      start_conv(avg, 4095, 0);
      run_set(avg, 4, "rand");
      accept(1'b0, "rand");
    end

    // Full-scale samples, each rise coincides with meas_cnt == timeout
    samp = '{4095, 4095, 4095, 4095, 4095, 4095, 4095, 4095};
    start_conv(3, 4095, 0);
    run_set(3, 4, "fullscale");
    check("fullscale_err", err_timeout, 0);
    accept(1'b0, "fullscale");

    samp = '{30};
    start_conv(0, 30, 0);
    run_set(0, 4, "rise_at_tmo");
    check("rise_at_tmo_err", err_timeout, 0);
    accept(1'b0, "rise_at_tmo");

    // Timeout with sns_done held low, then a new start clears the flag
    start_conv(0, 50, 0);
    expect_timeout(50, "tmo50");
    tick();
    tick();
    check("tmo50_sticky", err_timeout, 1);
    samp = '{7};
    start_conv(0, 4095, 0);
    check("tmo_clear_on_start", err_timeout, 0);
    run_set(0, 4, "after_tmo");
    accept(1'b0, "after_tmo");

    // Level already high on MEASURE entry never counts
    sns_done = 1'b1;
    start_conv(0, 20, 0);
    expect_timeout(20, "stuck_high");
    sns_done = 1'b0;
    tick();

    // Continuous mode: WAIT spans period+1 cycles before the 4 SRST cycles
    cont_en = 1'b1;
    samp = '{$urandom_range(0, 60)};
    start_conv(0, 4095, 10);
    run_set(0, 4, "cont1");
    accept(1'b1, "cont1");
    for (int k = 0; k < 2; k++) begin
      samp = '{$urandom_range(0, 60)};
      run_set(0, 15, "cont_n");
      accept(1'b1, "cont_n");
    end
    tick();
    tick();
    cont_en = 1'b0;
    tick();
    check("cont_drop_busy", busy, 0);

    cont_en = 1'b1;
    per = $urandom_range(0, 12);
    samp = '{$urandom_range(0, 60), $urandom_range(0, 60)};
    start_conv(1, 4095, per);
    run_set(1, 4, "cont_rand");
    accept(1'b1, "cont_rand");
    samp = '{$urandom_range(0, 60), $urandom_range(0, 60)};
    run_set(1, per + 5, "cont_rand2");
    accept(1'b1, "cont_rand2");
    samp = '{$urandom_range(0, 60)};
    start_conv(0, 4095, 0);
    check("cont_start_ignored_in_wait", busy, 1);
    cont_en = 1'b0;
    tick();
    check("cont_p0_drop_busy", busy, 0);

    cont_en = 1'b1;
    samp = '{5};
    start_conv(0, 4095, 0);
    run_set(0, 4, "p0_a");
    accept(1'b1, "p0_a");
    samp = '{9};
    run_set(0, 5, "p0_b");
    cont_en = 1'b0;
    accept(1'b0, "p0_b");

    // start and config changes while busy are ignored
    samp = '{40};
    start_conv(0, 4095, 0);
    start = 1'b1;
    avg_log2 = 2'd3;
    timeout = 12'd5;
    run_set(0, 4, "busy_start");
    tick();
    check("busy_start_out_hold", result_valid, 1);
    start = 1'b0;
    accept(1'b0, "busy_start");

    // Reset mid-MEASURE, with start asserted in the same cycle
    start_conv(0, 4095, 0);
    for (int i = 0; i < 12; i++) tick();
    check("mid_meas_sns_rst", sns_rst, 0);
    reset = 1'b1;
    start = 1'b1;
    tick();
    check_reset_vals("rst_meas");
    reset = 1'b0;
    start = 1'b0;
    tick();
    check("rst_meas_idle", busy, 0);

    // Reset mid-OUTPUT, with result_ready asserted in the same cycle
    samp = '{77};
    start_conv(0, 4095, 0);
    run_set(0, 4, "pre_rst_out");
    reset = 1'b1;
    result_ready = 1'b1;
    tick();
    check_reset_vals("rst_out");
    reset = 1'b0;
    result_ready = 1'b0;

    // Reset clears the sticky timeout flag
    start_conv(0, 3, 0);
    expect_timeout(3, "tmo3");
    reset = 1'b1;
    tick();
    check_reset_vals("rst_err");
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
